// File: rtl/free_list_if.sv
// Rename/retire handshake bundle for the physical-register free pool.
interface free_list_if #(
  parameter int PREG_W = 6
);
  logic              alloc_req_1;
  logic              alloc_req_2;
  logic              alloc_ok;
  logic [PREG_W-1:0] pd_1;
  logic [PREG_W-1:0] pd_2;
  logic              retire_flag_1;
  logic [PREG_W-1:0] fp_ind_1;
  logic              retire_flag_2;
  logic [PREG_W-1:0] fp_ind_2;
  logic [PREG_W-1:0] free_count;
  logic              empty;
  logic              err_free;

  modport master (
    output alloc_req_1, alloc_req_2, retire_flag_1, fp_ind_1, retire_flag_2, fp_ind_2,
    input  alloc_ok, pd_1, pd_2, free_count, empty, err_free
  );

  modport slave (
    input  alloc_req_1, alloc_req_2, retire_flag_1, fp_ind_1, retire_flag_2, fp_ind_2,
    output alloc_ok, pd_1, pd_2, free_count, empty, err_free
  );
endinterface

// File: rtl/free_list.sv
// Physical-register free pool: circular FIFO of free register indices that
// hands up to two registers per cycle to rename and accepts up to two frees
// per cycle from retire. A membership bitmap rejects p0, double frees and
// duplicate pairs; any rejected free raises a sticky error flag.
module free_list #(
  parameter int NUM_PREGS = 64,
  parameter int NUM_AREGS = 32,
  parameter int PREG_W    = 6
) (
  input logic        clk,
  input logic        rst_n,
  free_list_if.slave bus
);
  localparam int DEPTH = NUM_PREGS - NUM_AREGS;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PREG_W + 1;

  logic [PREG_W-1:0]    r_fifo [DEPTH];
  logic [PTR_W-1:0]     r_head;
  logic [PTR_W-1:0]     r_tail;
  logic [PREG_W-1:0]    r_count;
  logic                 r_empty;
  logic                 r_err;
  logic [NUM_PREGS-1:0] r_bitmap;

  logic [1:0]       w_nreq;
  logic [1:0]       w_grant;
  logic [1:0]       w_nfree;
  logic             w_alloc_ok;
  logic             w_leg1;
  logic             w_leg2;
  logic             w_ill;
  logic [PTR_W-1:0] w_head_p1;
  logic [PTR_W-1:0] w_tail_2;
  logic [CNT_W-1:0] w_room;
  logic [CNT_W-1:0] w_count_next;

  // Grant decision, granted indices and free legality, all from pre-edge state
  always_comb begin
    w_nreq     = {1'b0, bus.alloc_req_1} + {1'b0, bus.alloc_req_2};
    w_alloc_ok = ({{(PREG_W-2){1'b0}}, w_nreq} <= r_count);
    w_grant    = w_alloc_ok ? w_nreq : 2'd0;
    w_head_p1  = r_head + PTR_W'(1);

    bus.alloc_ok = w_alloc_ok;
    bus.pd_1     = r_fifo[r_head];
    bus.pd_2     = (bus.alloc_req_1 && bus.alloc_req_2) ? r_fifo[w_head_p1] : r_fifo[r_head];

    w_room = CNT_W'(DEPTH) - {1'b0, r_count} + {{(CNT_W-2){1'b0}}, w_grant};
    w_leg1 = bus.retire_flag_1 && (bus.fp_ind_1 != '0) && !r_bitmap[bus.fp_ind_1]
             && (w_room >= CNT_W'(1));
    w_leg2 = bus.retire_flag_2 && (bus.fp_ind_2 != '0) && !r_bitmap[bus.fp_ind_2]
             && !(bus.retire_flag_1 && (bus.fp_ind_1 == bus.fp_ind_2))
             && (w_room >= (w_leg1 ? CNT_W'(2) : CNT_W'(1)));
    w_nfree = {1'b0, w_leg1} + {1'b0, w_leg2};
    w_ill   = (bus.retire_flag_1 && !w_leg1) || (bus.retire_flag_2 && !w_leg2);

    w_tail_2     = w_leg1 ? (r_tail + PTR_W'(1)) : r_tail;
    w_count_next = {1'b0, r_count} - {{(CNT_W-2){1'b0}}, w_grant}
                   + {{(CNT_W-2){1'b0}}, w_nfree};

    bus.free_count = r_count;
    bus.empty      = r_empty;
    bus.err_free   = r_err;
  end

  // Pool state: reset loads p(NUM_AREGS)..p(NUM_PREGS-1); each edge commits grants and legal frees
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_fifo[i] <= PREG_W'(NUM_AREGS + i);
      end
      for (int i = 0; i < NUM_PREGS; i++) begin
        r_bitmap[i] <= (i >= NUM_AREGS);
      end
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= PREG_W'(DEPTH);
      r_empty <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_head <= r_head + PTR_W'(w_grant);
      if (w_grant != 2'd0) begin
        r_bitmap[r_fifo[r_head]] <= 1'b0;
      end
      if (w_grant == 2'd2) begin
        r_bitmap[r_fifo[w_head_p1]] <= 1'b0;
      end
      if (w_leg1) begin
        r_fifo[r_tail]             <= bus.fp_ind_1;
        r_bitmap[bus.fp_ind_1]     <= 1'b1;
      end
      if (w_leg2) begin
        r_fifo[w_tail_2]           <= bus.fp_ind_2;
        r_bitmap[bus.fp_ind_2]     <= 1'b1;
      end
      r_tail  <= r_tail + PTR_W'(w_nfree);
      r_count <= w_count_next[PREG_W-1:0];
      r_empty <= (w_count_next == '0);
      if (w_ill) begin
        r_err <= 1'b1;
      end
    end
  end
endmodule
